instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/core_pkg.sv | 26 ++
 rtl/instruction_fetch.sv | 160 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types and constants. Holds the fetch state
//               encoding and the datapath widths. FAULT and HALT exist only
//               when FETCH_MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_STREAM = 3'd1,
        ST_HOLD   = 3'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_FAULT  = 3'd3,
        ST_HALT   = 3'd4
`endif
    } fetch_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Streams instructions from a synchronous read-only instruction
//               memory (one-cycle read latency) to decode with a valid/ready
//               handshake, one instruction per cycle. A redirect restarts
//               fetch with a fixed two-cycle bubble.
//
// Ports       : clk, rst (async, active high)
//               imem_addr  -> word address to instruction memory
//               imem_data  <- read data, one cycle after imem_addr
//               redirect_valid / redirect_pc <- fetch restart request
//               out_valid / out_ready        <- decode handshake
//               out_instr / out_pc / out_fault -> instruction to decode
//
// Config      : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//               non-word-aligned target emits a single fault beat and then
//               halts until the next redirect. When undefined the low two
//               bits of redirect_pc are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import core_pkg::*;
#(
    parameter int                DEPTH    = 4096,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [$clog2(DEPTH)-1:0] imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_fault
);

    localparam int c_AW = $clog2(DEPTH);

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      w_fetch_pc_nxt;
    logic [XLEN-1:0]      r_resp_pc;
    logic [XLEN-1:0]      w_resp_pc_nxt;
    logic [INSTR_W-1:0]   r_hold_instr;
    logic [INSTR_W-1:0]   w_hold_instr_nxt;
    logic [XLEN-1:0]      w_fetch_pc_inc;

    // Natural 32-bit wrap of the increment.
    assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

    // Address is driven straight from the register so it tracks RESET_PC
    // while rst is held; upper bits drop out, giving the modulo-DEPTH wrap.
    assign imem_addr = r_fetch_pc[c_AW+1:2];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = |redirect_pc[1:0];
`else
    logic w_unused_redirect_lsb;
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= '0;
            r_hold_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_resp_pc    <= w_resp_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_resp_pc_nxt    = r_resp_pc;
        w_hold_instr_nxt = r_hold_instr;
        out_valid        = 1'b0;
        out_instr        = '0;
        out_pc           = r_resp_pc;
        out_fault        = 1'b0;

        case (r_state)
            // Address presented this cycle; its data shows up next cycle.
            ST_BOOT: begin
                w_state_nxt    = ST_STREAM;
                w_resp_pc_nxt  = r_fetch_pc;
                w_fetch_pc_nxt = w_fetch_pc_inc;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_instr = imem_data;
                if (out_ready) begin
                    w_resp_pc_nxt  = r_fetch_pc;
                    w_fetch_pc_nxt = w_fetch_pc_inc;
                end else begin
                    // Capture the word now: memory output moves on next cycle.
                    // fetch_pc is kept so the next word is re-read on release.
                    w_hold_instr_nxt = imem_data;
                    w_state_nxt      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                out_instr = r_hold_instr;
                if (out_ready) begin
                    w_resp_pc_nxt  = r_fetch_pc;
                    w_fetch_pc_nxt = w_fetch_pc_inc;
                    w_state_nxt    = ST_STREAM;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            // resp_pc carries the offending target captured at redirect.
            ST_FAULT: begin
                out_valid = 1'b1;
                out_fault = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
`endif
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        // Redirect overrides whatever the state machine decided above.
        if (redirect_valid) begin
            out_valid        = 1'b0;
            out_fault        = 1'b0;
            w_hold_instr_nxt = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
                w_resp_pc_nxt = redirect_pc;
                w_state_nxt   = ST_FAULT;
            end else begin
                w_fetch_pc_nxt = redirect_pc;
                w_state_nxt    = ST_BOOT;
            end
`else
            w_fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
            w_state_nxt    = ST_BOOT;
`endif
        end
    end

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A 256-word
//               instance is checked through a scoreboard of expected beats;
//               a 16-word instance sharing the same stimulus covers address
//               wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    logic [3:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic        s_out_valid;
    logic [31:0] s_out_instr;
    logic [31:0] s_out_pc;
    logic        s_out_fault;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] w);
        return {16'hA5C3, w[15:0]};
    endfunction

    always @(posedge clk) imem_data   <= memval({24'b0, imem_addr});
    always @(posedge clk) s_imem_data <= memval({28'b0, s_imem_addr});

    instruction_fetch #(.DEPTH(256), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
    );

    instruction_fetch #(.DEPTH(16), .RESET_PC(32'h0)) u_dut_small (
        .clk(clk), .rst(rst),
        .imem_addr(s_imem_addr), .imem_data(s_imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_instr(s_out_instr), .out_pc(s_out_pc), .out_fault(s_out_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back('{pc: pc, instr: memval({2'b00, pc[31:2]}), fault: 1'b0});
    endtask

    // Sample at the falling edge; every accepted beat is matched against the
    // oldest expected entry.
    task automatic sample();
        beat_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed pc %h, expected no accepted beat", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_pc", out_pc, e.pc);
                chk("beat_instr", out_instr, e.instr);
                chk("beat_fault", 32'(out_fault), 32'(e.fault));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(out_fault), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset release: bubble, then pc 0 and pc 4
        push(32'h0);
        push(32'h4);
        sample(); chk("boot_valid", 32'(out_valid), 32'd0); advance();
        sample(); advance();
        sample(); advance();

        // Backpressure for 3 cycles while pc 8 is on the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, 32'h8);
            chk("hold_instr", out_instr, memval(32'd2));
            advance();
        end
        out_ready = 1'b1;
        push(32'h8);
        push(32'hC);
        push(32'h10);
        repeat (3) begin sample(); advance(); end
        chk("sb_drained_hold", 32'(sb.size()), 32'd0);

        // Redirect to 0x100 while in HOLD (pc 0x14 must never be accepted)
        out_ready = 1'b0;
        sample(); advance();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        out_ready      = 1'b1;
        sample(); chk("redir_bubble0", 32'(out_valid), 32'd0); advance();
        redirect_valid = 1'b0;
        sample(); chk("redir_bubble1", 32'(out_valid), 32'd0); advance();
        push(32'h100);
        push(32'h104);
        sample(); advance();
        sample(); advance();
        chk("sb_drained_redir", 32'(sb.size()), 32'd0);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        sample(); chk("mis_bubble0", 32'(out_valid), 32'd0); advance();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        sb.push_back('{pc: 32'h102, instr: 32'h0, fault: 1'b1});
        sample(); chk("fault_flag", 32'(out_fault), 32'd1); advance();
        for (int i = 0; i < 3; i++) begin
            sample(); chk("halt_valid", 32'(out_valid), 32'd0); advance();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sample(); chk("resume_bubble0", 32'(out_valid), 32'd0); advance();
        redirect_valid = 1'b0;
        sample(); chk("resume_bubble1", 32'(out_valid), 32'd0); advance();
        push(32'h200);
        push(32'h204);
`else
        sample(); chk("mis_bubble1", 32'(out_valid), 32'd0); advance();
        push(32'h100);
        push(32'h104);
`endif
        sample(); advance();
        sample(); advance();
        chk("sb_drained_mis", 32'(sb.size()), 32'd0);

        // Address wrap on the 16-word instance
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        sample(); advance();
        redirect_valid = 1'b0;
        sample(); advance();
        for (int k = 0; k < 5; k++) push(32'h30 + 32'(4 * k));
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("small_pc", s_out_pc, 32'h30 + 32'(4 * k));
            if (k == 2) chk("small_addr_15", 32'(s_imem_addr), 32'd15);
            if (k == 3) chk("small_addr_wrap", 32'(s_imem_addr), 32'd0);
            if (k == 4) chk("small_wrap_instr", s_out_instr, memval(32'd0));
            advance();
        end
        chk("sb_drained_wrap", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-stream: outputs drop with no clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_valid_small", 32'(s_out_valid), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'd0);
        #10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(32'h0);
        push(32'h4);
        sample(); chk("rerun_boot_valid", 32'(out_valid), 32'd0); advance();
        sample(); advance();
        sample(); advance();
        chk("sb_drained_rst", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire
